// File: rtl/interface_spi_slave.sv
// SPI mode-0 slave: oversampled SCK/SSEL/MOSI, BUFFER_SIZE-bit MSB-first frames, rx_data update on valid frame, watchdog.
// Define SPI_MSGID_CHECK_EN to also require the first 32 received bits to equal MSGID.
module interface_spi_slave #(
  parameter int unsigned BUFFER_SIZE = 96,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter logic [31:0] TIMEOUT     = 32'd4800000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   SPI_SCK,
  input  logic                   SPI_SSEL,
  input  logic                   SPI_MOSI,
  output logic                   SPI_MISO,
  output logic [BUFFER_SIZE-1:0] rx_data,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic                   pkg_timeout
);

  localparam int unsigned   CW       = $clog2(BUFFER_SIZE + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(BUFFER_SIZE);
  localparam logic [CW-1:0] CNT_SAT  = CW'(BUFFER_SIZE + 1);

  logic [2:0]             r_sck_sync;
  logic [2:0]             r_ssel_sync;
  logic [2:0]             r_mosi_sync;
  logic [BUFFER_SIZE-1:0] r_rx_shift;
  logic [BUFFER_SIZE-1:0] r_tx_shift;
  logic [BUFFER_SIZE-1:0] r_rx_data;
  logic [CW-1:0]          r_bit_cnt;
  logic                   r_miso;
  logic [31:0]            r_to_cnt;
  logic                   r_pkg_timeout;

  logic w_sck_rise, w_sck_fall, w_ssel_fall, w_ssel_rise, w_ssel_low, w_mosi;
  logic w_hdr_ok, w_accept;

  assign w_sck_rise  =  r_sck_sync[1]  & ~r_sck_sync[2];
  assign w_sck_fall  = ~r_sck_sync[1]  &  r_sck_sync[2];
  assign w_ssel_fall = ~r_ssel_sync[1] &  r_ssel_sync[2];
  assign w_ssel_rise =  r_ssel_sync[1] & ~r_ssel_sync[2];
  assign w_ssel_low  = ~r_ssel_sync[1];
  assign w_mosi      =  r_mosi_sync[2];

`ifdef SPI_MSGID_CHECK_EN
  assign w_hdr_ok = (r_rx_shift[BUFFER_SIZE-1 -: 32] == MSGID);
`else
  logic w_unused_msgid;
  assign w_unused_msgid = ^MSGID;
  assign w_hdr_ok       = 1'b1;
`endif

  assign w_accept = w_ssel_rise && (r_bit_cnt == CNT_FULL) && w_hdr_ok;

  // SSEL synchroniser resets to idle-high so a reset taken mid-frame sees a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_ssel_sync <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0],  SPI_SCK};
      r_ssel_sync <= {r_ssel_sync[1:0], SPI_SSEL};
      r_mosi_sync <= {r_mosi_sync[1:0], SPI_MOSI};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_bit_cnt  <= '0;
      r_miso     <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      if (w_ssel_fall) begin
        r_bit_cnt  <= '0;
        r_tx_shift <= tx_data;
        r_miso     <= tx_data[BUFFER_SIZE-1];
      end else if (w_ssel_low) begin
        if (w_sck_rise) begin
          r_rx_shift <= {r_rx_shift[BUFFER_SIZE-2:0], w_mosi};
          if (r_bit_cnt != CNT_SAT)
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        // Mode 0: the first MSB is already on the wire, so skip the fall before the first rise.
        if (w_sck_fall && (r_bit_cnt != '0)) begin
          r_tx_shift <= {r_tx_shift[BUFFER_SIZE-2:0], 1'b0};
          r_miso     <= r_tx_shift[BUFFER_SIZE-2];
        end
      end else begin
        r_miso <= 1'b0;
      end
      if (w_accept)
        r_rx_data <= r_rx_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_pkg_timeout <= 1'b1;
    end else if (w_accept) begin
      r_to_cnt      <= '0;
      r_pkg_timeout <= 1'b0;
    end else begin
      if (r_to_cnt != TIMEOUT)
        r_to_cnt <= r_to_cnt + 32'd1;
      if ((r_to_cnt + 32'd1) >= TIMEOUT)
        r_pkg_timeout <= 1'b1;
    end
  end

  assign SPI_MISO    = r_miso;
  assign rx_data     = r_rx_data;
  assign pkg_timeout = r_pkg_timeout;

endmodule

// File: tb/tb_interface_spi_slave.sv
// Randomised frame-level bench for interface_spi_slave with a queue-based scoreboard.
module tb_interface_spi_slave;

  localparam int          B       = 96;
  localparam logic [31:0] MSGID   = 32'h17a17a17;
  localparam logic [31:0] TIMEOUT = 32'd100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         SPI_SCK, SPI_SSEL, SPI_MOSI;
  logic         SPI_MISO;
  logic [B-1:0] rx_data;
  logic [B-1:0] tx_data;
  logic         pkg_timeout;

  interface_spi_slave #(.BUFFER_SIZE(B), .MSGID(MSGID), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .SPI_SCK(SPI_SCK), .SPI_SSEL(SPI_SSEL), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .rx_data(rx_data), .tx_data(tx_data), .pkg_timeout(pkg_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [B-1:0] rx;
    bit           acc;
    logic [B-1:0] tx;
    int           nmiso;
  } exp_t;

  exp_t         exp_q[$];
  logic [B-1:0] model_rx;
  logic [B-1:0] cap;
  int           ncap;
  int           checks   = 0;
  int           failures = 0;

  task automatic check(input string name, input logic [B-1:0] act, input logic [B-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // What the master sees on MISO at each SCK rising edge of the current frame.
  always @(negedge SPI_SSEL) begin
    ncap = 0;
    cap  = '0;
  end
  always @(posedge SPI_SCK) begin
    if (!SPI_SSEL && rst_n) begin
      if (ncap < B) cap[B-1-ncap] = SPI_MISO;
      ncap++;
    end
  end

  // Scoreboard monitor: once SSEL rises and the synchroniser has settled, compare the frame outcome.
  initial begin
    exp_t         e;
    logic [B-1:0] ones, mask;
    ones = '1;
    wait (rst_n === 1'b1);
    forever begin
      @(posedge SPI_SSEL);
      repeat (5) @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=empty required=entry");
      end else begin
        e = exp_q.pop_front();
        check("rx_data", rx_data, e.rx);
        check("miso_idle", {{(B-1){1'b0}}, SPI_MISO}, '0);
        if (e.acc) check("pkg_timeout_clear", {{(B-1){1'b0}}, pkg_timeout}, '0);
        if (e.nmiso > 0) begin
          mask = ~(ones >> e.nmiso);
          check("miso_bits", cap & mask, e.tx & mask);
        end
      end
    end
  end

  task automatic spi_bits(input logic [B-1:0] data, input int first, input int last);
    for (int i = first; i < last; i++) begin
      SPI_MOSI = (i < B) ? data[B-1-i] : 1'($urandom);
      if (i == 10) tx_data = {$urandom, $urandom, $urandom};
      repeat (5) @(negedge clk);
      SPI_SCK = 1'b1;
      repeat (5) @(negedge clk);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [B-1:0] data, input logic [B-1:0] tx, input int n, input bit chk_miso);
    exp_t e;
    bit   hdr_ok;
    hdr_ok = 1'b1;
`ifdef SPI_MSGID_CHECK_EN
    hdr_ok = (data[B-1 -: 32] == MSGID);
`endif
    e.acc   = (n == B) && hdr_ok;
    if (e.acc) model_rx = data;
    e.rx    = model_rx;
    e.tx    = tx;
    e.nmiso = chk_miso ? ((n < B) ? n : B) : 0;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [B-1:0] data, input logic [B-1:0] tx, input int n, input bit tail);
    tx_data = tx;
    @(negedge clk);
    SPI_SSEL = 1'b0;
    repeat (5) @(negedge clk);
    spi_bits(data, 0, n);
    repeat (5) @(negedge clk);
    push_exp(data, tx, n, 1'b1);
    SPI_SSEL = 1'b1;
    if (tail) begin
      repeat (15) @(negedge clk);
      // SCK activity while deselected must be ignored.
      repeat (3) begin
        SPI_SCK = 1'b1; repeat (2) @(negedge clk);
        SPI_SCK = 1'b0; repeat (2) @(negedge clk);
      end
    end
  endtask

  function automatic logic [B-1:0] rand_frame(input bit good_hdr);
    logic [B-1:0] f;
    f = {$urandom, $urandom, $urandom};
    if (good_hdr) f[B-1 -: 32] = MSGID;
    return f;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit           seen;
    int           n, r;
    logic [B-1:0] d;
    rst_n = 1'b0; SPI_SCK = 1'b0; SPI_SSEL = 1'b1; SPI_MOSI = 1'b0; tx_data = '0;
    model_rx = '0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, '0);
    check("reset_miso", {{(B-1){1'b0}}, SPI_MISO}, '0);
    check("reset_pkg_timeout", {{(B-1){1'b0}}, pkg_timeout}, {{(B-1){1'b0}}, 1'b1});
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reference frame, then exact watchdog timing after the accept.
    send_frame(96'h17a17a17a17a17a17a17a17a, 96'h61746164_98880000_55000000, B, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = (pkg_timeout === 1'b0);
    end
    check("accept_clears_timeout", {{(B-1){1'b0}}, seen}, {{(B-1){1'b0}}, 1'b1});
    repeat (99) @(negedge clk);
    check("timeout_not_yet", {{(B-1){1'b0}}, pkg_timeout}, '0);
    @(negedge clk);
    check("timeout_asserted", {{(B-1){1'b0}}, pkg_timeout}, {{(B-1){1'b0}}, 1'b1});
    repeat (20) @(negedge clk);

    send_frame(rand_frame(1'b1), {$urandom, $urandom, $urandom}, B - 1, 1'b1);
    send_frame(rand_frame(1'b1), {$urandom, $urandom, $urandom}, B + 1, 1'b1);
    d = rand_frame(1'b0);
    d[B-1 -: 32] = 32'hdeadbeef;
    send_frame(d, {$urandom, $urandom, $urandom}, B, 1'b1);
    send_frame(rand_frame(1'b1), {$urandom, $urandom, $urandom}, B, 1'b1);

    // Reset in the middle of a frame: the remainder forms a short frame and is rejected.
    d = rand_frame(1'b1);
    tx_data = {$urandom, $urandom, $urandom};
    @(negedge clk);
    SPI_SSEL = 1'b0;
    repeat (5) @(negedge clk);
    spi_bits(d, 0, 40);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_rx_data", rx_data, '0);
    check("midreset_pkg_timeout", {{(B-1){1'b0}}, pkg_timeout}, {{(B-1){1'b0}}, 1'b1});
    rst_n = 1'b1;
    model_rx = '0;
    spi_bits(d, 40, B);
    repeat (5) @(negedge clk);
    push_exp(d, tx_data, B - 40, 1'b0);
    SPI_SSEL = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(rand_frame(1'b1), {$urandom, $urandom, $urandom}, B, 1'b1);

    for (int f = 0; f < 16; f++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       n = B - 1;
        1:       n = B + 1;
        2:       n = $urandom_range(1, 40);
        3:       n = B + 4;
        default: n = B;
      endcase
      send_frame(rand_frame($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom}, n, 1'b1);
    end

    repeat (20) @(negedge clk);
    check("sb_drain", B'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
